// File: rtl/vga_must_pkg.sv
// Shared timing defaults, derived frame constants and pixel types for the
// 640x480@60 VGA controller.
package vga_must_pkg;

  localparam int H_SYNC_DEF  = 96;
  localparam int H_BACK_DEF  = 48;
  localparam int H_VALID_DEF = 640;
  localparam int H_FRONT_DEF = 16;
  localparam int V_SYNC_DEF  = 2;
  localparam int V_BACK_DEF  = 33;
  localparam int V_VALID_DEF = 480;
  localparam int V_FRONT_DEF = 10;

  localparam int H_TOTAL = H_SYNC_DEF + H_BACK_DEF + H_VALID_DEF + H_FRONT_DEF;
  localparam int V_TOTAL = V_SYNC_DEF + V_BACK_DEF + V_VALID_DEF + V_FRONT_DEF;
  localparam int H_ACT0  = H_SYNC_DEF + H_BACK_DEF;
  localparam int V_ACT0  = V_SYNC_DEF + V_BACK_DEF;

  localparam logic [9:0] NO_REQ_X = 10'h3FF;
  localparam logic [8:0] NO_REQ_Y = 9'h1FF;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

endpackage

// File: rtl/vga_cnt_must.sv
// Wrap counter with increment enable; wrap is high on the enabled cycle that
// takes the count from TOTAL-1 back to 0.
module vga_cnt_must #(
  parameter int TOTAL = 800,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  assign wrap = en && (cnt == W'(TOTAL - 1));

  always_ff @(posedge clk) begin
    if (srst)
      cnt <= '0;
    else if (wrap)
      cnt <= '0;
    else if (en)
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/vga_ctrl_must.sv
// VGA timing generator: decodes h/v counters into syncs, a one-cycle-early
// pixel request and the gated colour returned by the picture generator.
module vga_ctrl_must
  import vga_must_pkg::*;
#(
  parameter int H_SYNC  = H_SYNC_DEF,
  parameter int H_BACK  = H_BACK_DEF,
  parameter int H_VALID = H_VALID_DEF,
  parameter int H_FRONT = H_FRONT_DEF,
  parameter int V_SYNC  = V_SYNC_DEF,
  parameter int V_BACK  = V_BACK_DEF,
  parameter int V_VALID = V_VALID_DEF,
  parameter int V_FRONT = V_FRONT_DEF
) (
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        pix_req,
  output logic        hsync,
  output logic        vsync,
  output logic        rgb_valid,
  output logic [15:0] vga_rgb,
  output logic        frame_start
);

  localparam int H_TOT = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int V_TOT = V_SYNC + V_BACK + V_VALID + V_FRONT;

  localparam logic [9:0] H_SYNC_C = 10'(H_SYNC);
  localparam logic [9:0] H_VIS0   = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_VIS1   = 10'(H_SYNC + H_BACK + H_VALID);
  localparam logic [9:0] H_REQ0   = 10'(H_SYNC + H_BACK - 1);
  localparam logic [9:0] H_REQ1   = 10'(H_SYNC + H_BACK + H_VALID - 2);
  localparam logic [9:0] V_SYNC_C = 10'(V_SYNC);
  localparam logic [9:0] V_VIS0   = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_VIS1   = 10'(V_SYNC + V_BACK + V_VALID);

  logic [9:0] cnt_h;
  logic [9:0] cnt_v;
  logic       h_wrap;
  logic       v_wrap_unused;
  logic       v_act;
  rgb565_t    pix_c;

  vga_cnt_must #(.TOTAL(H_TOT), .W(10)) u_cnt_h (
    .clk  (vga_clk),
    .srst (sys_rst),
    .en   (1'b1),
    .cnt  (cnt_h),
    .wrap (h_wrap)
  );

  vga_cnt_must #(.TOTAL(V_TOT), .W(10)) u_cnt_v (
    .clk  (vga_clk),
    .srst (sys_rst),
    .en   (h_wrap),
    .cnt  (cnt_v),
    .wrap (v_wrap_unused)
  );

  assign hsync       = (cnt_h >= H_SYNC_C);
  assign vsync       = (cnt_v >= V_SYNC_C);
  assign frame_start = (cnt_h == 10'd0) && (cnt_v == 10'd0);

  assign v_act     = (cnt_v >= V_VIS0) && (cnt_v < V_VIS1);
  assign rgb_valid = v_act && (cnt_h >= H_VIS0) && (cnt_h < H_VIS1);

  // Request window leads the visible window by one clock to absorb the
  // generator's ROM read latency.
  assign pix_req = v_act && (cnt_h >= H_REQ0) && (cnt_h <= H_REQ1);
  assign pix_x   = pix_req ? (cnt_h - H_REQ0) : NO_REQ_X;
  assign pix_y   = pix_req ? 9'(cnt_v - V_VIS0) : NO_REQ_Y;

  assign pix_c   = pix_data;
  assign vga_rgb = rgb_valid ? pix_c : 16'h0000;

endmodule

// File: tb/tb_vga_ctrl_must.sv
// Bench for vga_ctrl_must: a default-timing instance through line 35 and a
// shrunken-timing instance over many frames, both with a 1-cycle pixel stub.
module tb_vga_ctrl_must;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic        rst_a, rst_b;
  logic        rst_q_a, rst_q_b;
  logic [15:0] pd_a, pd_b, rgb_a, rgb_b;
  logic [9:0]  px_a, px_b;
  logic [8:0]  py_a, py_b;
  logic        req_a, req_b, hs_a, hs_b, vs_a, vs_b, rv_a, rv_b, fs_a, fs_b;

  int n_chk  = 0;
  int n_pass = 0;
  int t_a    = 0;
  int t_b    = 0;
  logic [15:0] q_a[$];
  logic [15:0] q_b[$];

  vga_ctrl_must dut_a (
    .vga_clk (clk), .sys_rst (rst_a), .pix_data (pd_a),
    .pix_x (px_a), .pix_y (py_a), .pix_req (req_a),
    .hsync (hs_a), .vsync (vs_a), .rgb_valid (rv_a),
    .vga_rgb (rgb_a), .frame_start (fs_a)
  );

  // Small frame: H 4/3/10/2 -> 19 clocks, V 2/3/6/2 -> 13 lines, 247 clocks.
  vga_ctrl_must #(
    .H_SYNC (4), .H_BACK (3), .H_VALID (10), .H_FRONT (2),
    .V_SYNC (2), .V_BACK (3), .V_VALID (6),  .V_FRONT (2)
  ) dut_b (
    .vga_clk (clk), .sys_rst (rst_b), .pix_data (pd_b),
    .pix_x (px_b), .pix_y (py_b), .pix_req (req_b),
    .hsync (hs_b), .vsync (vs_b), .rgb_valid (rv_b),
    .vga_rgb (rgb_b), .frame_start (fs_b)
  );

  // Picture-generator stub with one cycle of latency, plus cycle-since-reset model.
  always @(posedge clk) begin
    pd_a    <= {px_a[4:0], py_a[5:0], px_a[4:0]};
    pd_b    <= {px_b[4:0], py_b[5:0], px_b[4:0]};
    t_a     <= rst_a ? 0 : t_a + 1;
    t_b     <= rst_b ? 0 : t_b + 1;
    rst_q_a <= rst_a;
    rst_q_b <= rst_b;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got === exp)
      n_pass = n_pass + 1;
    else
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // {hsync, vsync, frame_start, pix_req, rgb_valid, pix_x, pix_y}
  function automatic logic [23:0] exp_vec(input int h, input int v,
                                          input int hs, input int hb, input int hv,
                                          input int vs, input int vb, input int vv);
    int hact0, vact0;
    logic vact, req, vis;
    logic [9:0] x;
    logic [8:0] y;
    hact0 = hs + hb;
    vact0 = vs + vb;
    vact  = (v >= vact0) && (v < vact0 + vv);
    req   = vact && (h >= hact0 - 1) && (h <= hact0 + hv - 2);
    vis   = vact && (h >= hact0) && (h < hact0 + hv);
    x     = req ? 10'(h - hact0 + 1) : 10'h3FF;
    y     = req ? 9'(v - vact0) : 9'h1FF;
    return {(h >= hs), (v >= vs), (h == 0 && v == 0), req, vis, x, y};
  endfunction

  task automatic check_reset(input string who, input logic hs, input logic vs, input logic fs,
                             input logic rq, input logic rv, input logic [15:0] rgb,
                             input logic [9:0] px, input logic [8:0] py);
    check_val({who, "_rst_hsync"}, hs, 0);
    check_val({who, "_rst_vsync"}, vs, 0);
    check_val({who, "_rst_fstart"}, fs, 1);
    check_val({who, "_rst_req"}, rq, 0);
    check_val({who, "_rst_valid"}, rv, 0);
    check_val({who, "_rst_rgb"}, rgb, 0);
    check_val({who, "_rst_x"}, px, 10'h3FF);
    check_val({who, "_rst_y"}, py, 9'h1FF);
  endtask

  int hs_low_a = 0;

  always @(negedge clk) begin
    int h, v;
    logic [9:0] col;
    logic [8:0] row;
    logic [15:0] e;
    h = t_a % 800;
    v = (t_a / 800) % 525;
    if (rst_q_a) begin
      q_a.delete();
      check_reset("a", hs_a, vs_a, fs_a, req_a, rv_a, rgb_a, px_a, py_a);
      hs_low_a = (hs_a == 1'b0) ? 1 : 0;
    end else begin
      check_val("a_timing", {hs_a, vs_a, fs_a, req_a, rv_a, px_a, py_a},
                exp_vec(h, v, 96, 48, 640, 2, 33, 480));
      if (rv_a) begin
        check_val("a_sb_depth", (q_a.size() != 0), 1);
        if (q_a.size() != 0) begin
          e = q_a.pop_front();
          check_val("a_rgb", rgb_a, e);
        end
      end else begin
        check_val("a_rgb_blank", rgb_a, 0);
      end
      if (req_a) begin
        col = 10'(h - 143);
        row = 9'(v - 35);
        q_a.push_back({col[4:0], row[5:0], col[4:0]});
      end
      if (t_a < 800 && !hs_a) hs_low_a = hs_low_a + 1;
      if (t_a == 800) check_val("a_hsync_low", hs_low_a, 96);
      if (v == 35) begin
        case (h)
          143: begin
            check_val("a_l35_req143", req_a, 1);
            check_val("a_l35_x143", px_a, 0);
            check_val("a_l35_y143", py_a, 0);
            check_val("a_l35_valid143", rv_a, 0);
          end
          144: begin
            check_val("a_l35_valid144", rv_a, 1);
            check_val("a_l35_x144", px_a, 1);
          end
          782: check_val("a_l35_x782", px_a, 639);
          783: begin
            check_val("a_l35_req783", req_a, 0);
            check_val("a_l35_x783", px_a, 10'h3FF);
            check_val("a_l35_valid783", rv_a, 1);
          end
          784: check_val("a_l35_valid784", rv_a, 0);
          default: ;
        endcase
      end
      if (h == 799 && v >= 34)
        $display("a: line %0d complete, scoreboard depth %0d", v, q_a.size());
    end
  end

  int   vs_low_b = 0;
  int   vis_b    = 0;
  int   last_fs_b = 0;
  logic fs_seen_b = 1'b0;
  logic acc_ok_b  = 1'b0;
  logic first_req_pend_b = 1'b0;
  logic prev_wrap_b = 1'b0;
  int   frames_b = 0;

  always @(negedge clk) begin
    int h, v;
    logic [9:0] col;
    logic [8:0] row;
    logic [15:0] e;
    h = t_b % 19;
    v = (t_b / 19) % 13;
    if (rst_q_b) begin
      q_b.delete();
      check_reset("b", hs_b, vs_b, fs_b, req_b, rv_b, rgb_b, px_b, py_b);
      acc_ok_b = 1'b0;
      fs_seen_b = 1'b0;
      first_req_pend_b = 1'b1;
      prev_wrap_b = 1'b0;
    end else begin
      check_val("b_timing", {hs_b, vs_b, fs_b, req_b, rv_b, px_b, py_b},
                exp_vec(h, v, 4, 3, 10, 2, 3, 6));
      if (rv_b) begin
        check_val("b_sb_depth", (q_b.size() != 0), 1);
        if (q_b.size() != 0) begin
          e = q_b.pop_front();
          check_val("b_rgb", rgb_b, e);
        end
      end else begin
        check_val("b_rgb_blank", rgb_b, 0);
      end
      if (req_b) begin
        col = 10'(h - 6);
        row = 9'(v - 5);
        q_b.push_back({col[4:0], row[5:0], col[4:0]});
      end
      if (first_req_pend_b && req_b) begin
        check_val("b_first_req_cycle", t_b, 5 * 19 + 6);
        first_req_pend_b = 1'b0;
      end
      if (prev_wrap_b) check_val("b_wrap_fstart", fs_b, 1);
      prev_wrap_b = (h == 18 && v == 12);
      if (v == 10 && h == 15) check_val("b_last_req_y", py_b, 5);
      if (fs_b) begin
        if (fs_seen_b) check_val("b_fs_period", t_b - last_fs_b, 247);
        last_fs_b = t_b;
        fs_seen_b = 1'b1;
      end
      if (h == 0 && v == 0) begin
        if (acc_ok_b) begin
          check_val("b_vsync_low", vs_low_b, 38);
          check_val("b_visible", vis_b, 60);
          frames_b = frames_b + 1;
          $display("b: frame %0d vsync_low=%0d visible=%0d", frames_b, vs_low_b, vis_b);
        end
        acc_ok_b = 1'b1;
        vs_low_b = 0;
        vis_b    = 0;
      end
      if (!vs_b) vs_low_b = vs_low_b + 1;
      if (rv_b)  vis_b = vis_b + 1;
    end
  end

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    // Pulse reset into the small instance mid-frame, at line 8 column 9.
    repeat (3 * 247 + 8 * 19 + 9) @(posedge clk);
    #1 rst_b = 1'b1;
    @(posedge clk);
    #1 rst_b = 1'b0;
    repeat (28000) @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_ctrl_must.md
Name: vga_ctrl_must

Overview:
- Generates 640x480@60 Hz VGA timing from a 25 MHz pixel clock (40 ns period).
- Sits directly upstream of the picture generator. It drives pix_x/pix_y into vga_pic_must and consumes the 16-bit RGB565 pix_data that comes back.
- Issues coordinates one cycle early to cover the generator's 1-cycle ROM latency. Gates the returned colour onto vga_rgb during the visible area, alongside the hsync/vsync outputs.

Parameters:
- H_SYNC, 96, hsync pulse width in clocks
- H_BACK, 48, horizontal back porch
- H_VALID, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- V_SYNC, 2, vsync pulse width in lines
- V_BACK, 33, vertical back porch
- V_VALID, 480, visible lines
- V_FRONT, 10, vertical front porch

Ports:
- vga_clk  in  1  pixel clock, 25 MHz; sole clock
- sys_rst  in  1  synchronous reset, active-high
- pix_data  in  16  RGB565 from the picture generator, valid 1 cycle after pix_x/pix_y
- pix_x  out  10  requested column 0..639; 10'h3FF when no request
- pix_y  out  9  requested row 0..479; 9'h1FF when no request
- pix_req  out  1  pix_x/pix_y carry a valid request this cycle
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- rgb_valid  out  1  vga_rgb carries a visible pixel
- vga_rgb  out  16  pixel to DAC; 16'h0000 when not rgb_valid
- frame_start  out  1  one-cycle pulse at cnt_h==0 && cnt_v==0

Behaviour:
- Derived constants:
  - H_TOTAL = 800; V_TOTAL = 525.
  - H_ACT0 = H_SYNC + H_BACK = 144; V_ACT0 = V_SYNC + V_BACK = 35.
- Counters: cnt_h (10 b) and cnt_v (10 b) are the only state registers.
  - Both are 0 on any clock edge where sys_rst = 1, including mid-frame; timing restarts from (0,0) on the first edge after release.
  - cnt_h increments every clock and wraps from H_TOTAL-1 to 0.
  - cnt_v increments only when cnt_h == H_TOTAL-1 and wraps from V_TOTAL-1 to 0. A simultaneous h-wrap and v-wrap takes both to 0 on the same edge.
- All outputs are combinational decodes of cnt_h, cnt_v and pix_data; none are separately registered.
- Sync signals:
  - hsync = 0 iff cnt_h < H_SYNC; vsync = 0 iff cnt_v < V_SYNC.
- Visible area:
  - v_act = (V_ACT0 <= cnt_v < V_ACT0 + V_VALID).
  - rgb_valid = v_act && (H_ACT0 <= cnt_h < H_ACT0 + H_VALID), i.e. cnt_h 144..783 and cnt_v 35..514.
  - vga_rgb = rgb_valid ? pix_data : 16'h0000.
- Request window, 1-cycle lookahead:
  - pix_req = v_act && (H_ACT0-1 <= cnt_h <= H_ACT0 + H_VALID - 2), i.e. cnt_h 143..782.
  - When pix_req = 1: pix_x = cnt_h - (H_ACT0-1) and pix_y = cnt_v - V_ACT0, both truncated to port width.
  - When pix_req = 0: pix_x = 10'h3FF and pix_y = 9'h1FF.
- Alignment invariant: the coordinate presented when pix_req is high at cycle N is the coordinate displayed on vga_rgb at cycle N+1. rgb_valid is exactly pix_req delayed by one clock within a line.
- Reset values (sys_rst held, counters 0):
  - hsync = 0, vsync = 0, frame_start = 1.
  - pix_req = 0, rgb_valid = 0, vga_rgb = 0.
  - pix_x = 3FF, pix_y = 1FF.
- Width rules: counters and parameter comparisons are evaluated at 10 bits unsigned. Parameters must satisfy H_ACT0 >= 1, so the lookahead subtraction never underflows.

Decomposition:
- Package vga_must_pkg:
  - the eight timing parameters as defaults
  - H_TOTAL, V_TOTAL, H_ACT0, V_ACT0
  - the NO_REQ_X / NO_REQ_Y constants (3FF / 1FF)
  - an RGB565 colour typedef
- One sub-module is natural: vga_cnt_must, a parameterised wrap counter with an increment enable and a wrap flag output. It is instanced twice: once for h (enable = 1) and once for v (enable = h wrap).

Test Plan:
- Reset then release; hold sys_rst 3 cycles -> cnt (0,0), hsync=0, vsync=0, frame_start=1, pix_x=3FF, vga_rgb=0; 800 clocks later hsync has been low exactly 96 clocks.
- Line 35 edge: at cnt_h=143 -> pix_req=1, pix_x=0, pix_y=0, rgb_valid=0; at cnt_h=144 -> rgb_valid=1, pix_x=1; at cnt_h=782 -> pix_x=639; at cnt_h=783 -> pix_req=0, pix_x=3FF, rgb_valid=1; at cnt_h=784 -> rgb_valid=0.
- Latency model: stub returns pix_data = {pix_x[4:0], pix_y[5:0], pix_x[4:0]} registered 1 cycle -> every rgb_valid cycle, vga_rgb matches the expected value for column cnt_h-144 and row cnt_v-35; 0 outside the visible area.
- Frame period: frame_start pulses exactly every 420000 clocks; vsync low for 1600 clocks per frame; rgb_valid high for 307200 clocks per frame.
- Wrap: at cnt_h=799, cnt_v=524 -> next edge (0,0) and frame_start=1; line 514 last request pix_y=479; line 515 pix_req never asserts.
- Mid-frame reset: assert sys_rst at cnt_v=200, cnt_h=500 for 1 clock -> next edge outputs equal reset values; timing restarts and the first pix_req appears at cnt_v=35, cnt_h=143.
